// File: rtl/rs_multi_cdb.sv
`default_nettype none
// ============================================================================
// Module : rs_multi_cdb
// Reservation station that snoops NUM_CDB result buses and issues the oldest
// ready entry. Optional macro RS_DISPATCH_BYPASS_EN sends a ready dispatch
// straight to the output register when nothing stored is ready.
// Rev    : 1.0
// ============================================================================
module rs_multi_cdb #(
  parameter int DEPTH   = 8,
  parameter int ROB_W   = 3,
  parameter int OP_W    = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic [NUM_CDB-1:0]       cdb_valid_in,
  input  logic [NUM_CDB*ROB_W-1:0] cdb_tag_in,
  input  logic [NUM_CDB*32-1:0]    cdb_value_in,
  input  logic                     dec_valid_in,
  input  logic [OP_W-1:0]          dec_op_in,
  input  logic                     dec_wait1_in,
  input  logic                     dec_wait2_in,
  input  logic [ROB_W-1:0]         dec_tag1_in,
  input  logic [ROB_W-1:0]         dec_tag2_in,
  input  logic [31:0]              dec_val1_in,
  input  logic [31:0]              dec_val2_in,
  input  logic [ROB_W-1:0]         dec_rob_id_in,
  output logic                     full_out,
  output logic                     issue_valid_out,
  input  logic                     issue_ready_in,
  output logic [OP_W-1:0]          issue_op_out,
  output logic [31:0]              issue_opr1_out,
  output logic [31:0]              issue_opr2_out,
  output logic [ROB_W-1:0]         issue_rob_id_out
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] busy_q, busy_d, wait1_q, wait1_d, wait2_q, wait2_d;
  logic [OP_W-1:0]  op_q   [DEPTH];
  logic [OP_W-1:0]  op_d   [DEPTH];
  logic [ROB_W-1:0] tag1_q [DEPTH];
  logic [ROB_W-1:0] tag1_d [DEPTH];
  logic [ROB_W-1:0] tag2_q [DEPTH];
  logic [ROB_W-1:0] tag2_d [DEPTH];
  logic [ROB_W-1:0] rob_q  [DEPTH];
  logic [ROB_W-1:0] rob_d  [DEPTH];
  logic [31:0]      val1_q [DEPTH];
  logic [31:0]      val1_d [DEPTH];
  logic [31:0]      val2_q [DEPTH];
  logic [31:0]      val2_d [DEPTH];
  logic [DEPTH-1:0] age_q  [DEPTH];
  logic [DEPTH-1:0] age_d  [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             out_valid_q, out_valid_d;
  logic [OP_W-1:0]  out_op_q, out_op_d;
  logic [31:0]      out_opr1_q, out_opr1_d, out_opr2_q, out_opr2_d;
  logic [ROB_W-1:0] out_rob_q, out_rob_d;

  logic [DEPTH-1:0] ready;
  logic             any_ready, has_older, slot_free, accept, issued, byp, store;
  logic [IDX_W-1:0] sel_idx, free_idx;
  logic [32:0]      s1, s2, sw1, sw2;
  logic             nw1, nw2;
  logic [31:0]      nv1, nv2;

  // Returns {hit, value}; the lowest matching channel wins.
  function automatic logic [32:0] snoop(input logic [ROB_W-1:0]         tag,
                                        input logic [NUM_CDB-1:0]       vld,
                                        input logic [NUM_CDB*ROB_W-1:0] tags,
                                        input logic [NUM_CDB*32-1:0]    vals);
    logic [32:0] r;
    r = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*ROB_W +: ROB_W] == tag)) r = {1'b1, vals[k*32 +: 32]};
    end
    return r;
  endfunction

  always_comb begin
    ready     = busy_q & ~wait1_q & ~wait2_q;
    any_ready = |ready;
    has_older = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    // Oldest ready: a ready entry with no ready entry older than it.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      has_older = 1'b0;
      for (int j = 0; j < DEPTH; j++) has_older = has_older | (ready[j] & age_q[j][i]);
      if (ready[i] && !has_older) sel_idx = IDX_W'(i);
      if (!busy_q[i]) free_idx = IDX_W'(i);
    end
    s1        = snoop(dec_tag1_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    s2        = snoop(dec_tag2_in, cdb_valid_in, cdb_tag_in, cdb_value_in);
    nw1       = dec_wait1_in & ~s1[32];
    nw2       = dec_wait2_in & ~s2[32];
    nv1       = (dec_wait1_in && s1[32]) ? s1[31:0] : dec_val1_in;
    nv2       = (dec_wait2_in && s2[32]) ? s2[31:0] : dec_val2_in;
    slot_free = ~out_valid_q | issue_ready_in;
    accept    = dec_valid_in & ~full_q;
    issued    = slot_free & any_ready;
`ifdef RS_DISPATCH_BYPASS_EN
    byp       = accept & slot_free & ~any_ready & ~nw1 & ~nw2;
`else
    byp       = 1'b0;
`endif
    store     = accept & ~byp;
  end

  always_comb begin
    busy_d      = busy_q;
    wait1_d     = wait1_q;
    wait2_d     = wait2_q;
    op_d        = op_q;
    tag1_d      = tag1_q;
    tag2_d      = tag2_q;
    rob_d       = rob_q;
    val1_d      = val1_q;
    val2_d      = val2_q;
    age_d       = age_q;
    count_d     = count_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_opr1_d  = out_opr1_q;
    out_opr2_d  = out_opr2_q;
    out_rob_d   = out_rob_q;
    sw1         = '0;
    sw2         = '0;
    if (rdy_in) begin
      if (flush_in) begin
        busy_d      = '0;
        count_d     = '0;
        full_d      = 1'b0;
        out_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          sw1 = snoop(tag1_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
          sw2 = snoop(tag2_q[i], cdb_valid_in, cdb_tag_in, cdb_value_in);
          if (busy_q[i] && wait1_q[i] && sw1[32]) begin
            wait1_d[i] = 1'b0;
            val1_d[i]  = sw1[31:0];
          end
          if (busy_q[i] && wait2_q[i] && sw2[32]) begin
            wait2_d[i] = 1'b0;
            val2_d[i]  = sw2[31:0];
          end
        end
        if (slot_free) begin
          if (issued) begin
            out_valid_d     = 1'b1;
            out_op_d        = op_q[sel_idx];
            out_opr1_d      = val1_q[sel_idx];
            out_opr2_d      = val2_q[sel_idx];
            out_rob_d       = rob_q[sel_idx];
            busy_d[sel_idx] = 1'b0;
          end else if (byp) begin
            out_valid_d = 1'b1;
            out_op_d    = dec_op_in;
            out_opr1_d  = nv1;
            out_opr2_d  = nv2;
            out_rob_d   = dec_rob_id_in;
          end else begin
            out_valid_d = 1'b0;
          end
        end
        if (store) begin
          busy_d[free_idx]  = 1'b1;
          op_d[free_idx]    = dec_op_in;
          wait1_d[free_idx] = nw1;
          wait2_d[free_idx] = nw2;
          tag1_d[free_idx]  = dec_tag1_in;
          tag2_d[free_idx]  = dec_tag2_in;
          val1_d[free_idx]  = nv1;
          val2_d[free_idx]  = nv2;
          rob_d[free_idx]   = dec_rob_id_in;
          age_d[free_idx]   = '0;
          for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = busy_q[j];
        end
        count_d = count_q + CNT_W'(store) - CNT_W'(issued);
        full_d  = (count_d == CNT_W'(DEPTH));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q      <= '0;
      wait1_q     <= '0;
      wait2_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_opr1_q  <= '0;
      out_opr2_q  <= '0;
      out_rob_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        rob_q[i]  <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      busy_q      <= busy_d;
      wait1_q     <= wait1_d;
      wait2_q     <= wait2_d;
      count_q     <= count_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_opr1_q  <= out_opr1_d;
      out_opr2_q  <= out_opr2_d;
      out_rob_q   <= out_rob_d;
      op_q        <= op_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      rob_q       <= rob_d;
      val1_q      <= val1_d;
      val2_q      <= val2_d;
      age_q       <= age_d;
    end
  end

  assign full_out         = full_q;
  assign issue_valid_out  = out_valid_q;
  assign issue_op_out     = out_op_q;
  assign issue_opr1_out   = out_opr1_q;
  assign issue_opr2_out   = out_opr2_q;
  assign issue_rob_id_out = out_rob_q;
endmodule
`default_nettype wire

// File: tb/tb_rs_multi_cdb.sv
`default_nettype none
// Testbench for rs_multi_cdb: directed scenarios plus randomized traffic
// checked against a queue-ordered behavioural model.
module tb_rs_multi_cdb;
  localparam int DEPTH = 8, ROB_W = 3, OP_W = 4, NUM_CDB = 2;
`ifdef RS_DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
  logic [NUM_CDB-1:0] cdb_valid_in = '0;
  logic [NUM_CDB*ROB_W-1:0] cdb_tag_in = '0;
  logic [NUM_CDB*32-1:0] cdb_value_in = '0;
  logic dec_valid_in = 1'b0, dec_wait1_in = 1'b0, dec_wait2_in = 1'b0;
  logic [OP_W-1:0] dec_op_in = '0;
  logic [ROB_W-1:0] dec_tag1_in = '0, dec_tag2_in = '0, dec_rob_id_in = '0;
  logic [31:0] dec_val1_in = '0, dec_val2_in = '0;
  logic full_out, issue_valid_out, issue_ready_in = 1'b0;
  logic [OP_W-1:0] issue_op_out;
  logic [31:0] issue_opr1_out, issue_opr2_out;
  logic [ROB_W-1:0] issue_rob_id_out;

  rs_multi_cdb #(.DEPTH(DEPTH), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .dec_valid_in(dec_valid_in), .dec_op_in(dec_op_in), .dec_wait1_in(dec_wait1_in),
    .dec_wait2_in(dec_wait2_in), .dec_tag1_in(dec_tag1_in), .dec_tag2_in(dec_tag2_in),
    .dec_val1_in(dec_val1_in), .dec_val2_in(dec_val2_in), .dec_rob_id_in(dec_rob_id_in),
    .full_out(full_out), .issue_valid_out(issue_valid_out), .issue_ready_in(issue_ready_in),
    .issue_op_out(issue_op_out), .issue_opr1_out(issue_opr1_out),
    .issue_opr2_out(issue_opr2_out), .issue_rob_id_out(issue_rob_id_out));

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic             w1, w2;
    logic [ROB_W-1:0] t1, t2;
    logic [31:0]      v1, v2;
    logic [ROB_W-1:0] rob;
  } ent_t;

  ent_t mq[$];
  ent_t m_out = '0;
  bit   m_valid = 1'b0, m_full = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  int   exp_lat;

  function automatic logic [32:0] bus_lookup(input logic [ROB_W-1:0] t);
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb_valid_in[k] && cdb_tag_in[k*ROB_W +: ROB_W] == t)
        return {1'b1, cdb_value_in[k*32 +: 32]};
    return '0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_full  = 1'b0;
    m_out   = '0;
  endfunction

  // One clock edge of the station as seen from outside: oldest ready first.
  function automatic void model_step();
    ent_t n, e;
    logic [32:0] s;
    int idx;
    bit free_slot, acc, bypassed;
    if (!rdy_in) return;
    if (flush_in) begin
      mq.delete(); m_valid = 1'b0; m_full = 1'b0;
      return;
    end
    n = '{op: dec_op_in, w1: dec_wait1_in, w2: dec_wait2_in, t1: dec_tag1_in,
          t2: dec_tag2_in, v1: dec_val1_in, v2: dec_val2_in, rob: dec_rob_id_in};
    if (n.w1) begin s = bus_lookup(n.t1); if (s[32]) begin n.w1 = 1'b0; n.v1 = s[31:0]; end end
    if (n.w2) begin s = bus_lookup(n.t2); if (s[32]) begin n.w2 = 1'b0; n.v2 = s[31:0]; end end
    free_slot = !m_valid || issue_ready_in;
    acc = dec_valid_in && !m_full;
    idx = -1;
    for (int i = 0; i < mq.size(); i++)
      if (idx < 0 && !mq[i].w1 && !mq[i].w2) idx = i;
    for (int i = 0; i < mq.size(); i++) begin
      e = mq[i];
      if (e.w1) begin s = bus_lookup(e.t1); if (s[32]) begin e.w1 = 1'b0; e.v1 = s[31:0]; end end
      if (e.w2) begin s = bus_lookup(e.t2); if (s[32]) begin e.w2 = 1'b0; e.v2 = s[31:0]; end end
      mq[i] = e;
    end
    bypassed = 1'b0;
    if (free_slot) begin
      if (idx >= 0) begin
        m_out = mq[idx]; mq.delete(idx); m_valid = 1'b1;
      end else if (BYP && acc && !n.w1 && !n.w2) begin
        m_out = n; m_valid = 1'b1; bypassed = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (acc && !bypassed) mq.push_back(n);
    m_full = (mq.size() == DEPTH);
  endfunction

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle();
    dec_valid_in = 1'b0; flush_in = 1'b0; rdy_in = 1'b1; cdb_valid_in = '0;
    dec_wait1_in = 1'b0; dec_wait2_in = 1'b0;
  endtask

  task automatic drive(input logic [OP_W-1:0] op, input logic w1, input logic [ROB_W-1:0] t1,
                       input logic [31:0] v1, input logic w2, input logic [ROB_W-1:0] t2,
                       input logic [31:0] v2, input logic [ROB_W-1:0] rob);
    dec_valid_in = 1'b1; dec_op_in = op; dec_wait1_in = w1; dec_tag1_in = t1; dec_val1_in = v1;
    dec_wait2_in = w2; dec_tag2_in = t2; dec_val2_in = v2; dec_rob_id_in = rob;
  endtask

  task automatic test_reset();
    idle();
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (issue_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", issue_valid_out); end
    n_cmp++; if (full_out !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full_out); end
    n_cmp++; if ({issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out} !== '0) begin
      n_bad++; $display("FAIL reset_data: got op=%0h o1=%0h o2=%0h rob=%0h want all 0",
                        issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out); end
    rst_n_in = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int lat;
    idle(); issue_ready_in = 1'b1; lat = 0;
    drive(4'd3, 1'b0, 3'd0, 32'd5, 1'b0, 3'd0, 32'd7, 3'd2);
    for (int c = 1; c <= 6; c++) begin
      step(); dec_valid_in = 1'b0;
      if (issue_valid_out === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat); end
    n_cmp++; if ({issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out} !== {4'd3, 32'd5, 32'd7, 3'd2}) begin
      n_bad++; $display("FAIL basic_data: got op=%0d o1=%0d o2=%0d rob=%0d want 3 5 7 2",
                        issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out); end
    step();
    n_cmp++; if ({issue_valid_out, full_out} !== 2'b00) begin
      n_bad++; $display("FAIL basic_drain: got valid=%b full=%b want 0 0", issue_valid_out, full_out); end
  endtask

  task automatic test_wakeup_order();
    int cyc_b, cyc_a, exp_gap;
    logic [31:0] a_o1, a_o2, b_o1;
    idle(); issue_ready_in = 1'b1; cyc_b = -1; cyc_a = -1; exp_gap = BYP ? 2 : 1;
    a_o1 = 'x; a_o2 = 'x; b_o1 = 'x;
    drive(4'd1, 1'b1, 3'd4, 32'hDEAD, 1'b0, 3'd0, 32'd9, 3'd1);
    step();
    drive(4'd2, 1'b0, 3'd0, 32'h11, 1'b0, 3'd0, 32'h22, 3'd2);
    step(); idle();
    for (int c = 0; c < 8; c++) begin
      if (issue_valid_out === 1'b1 && issue_rob_id_out == 3'd2 && cyc_b < 0) begin cyc_b = c; b_o1 = issue_opr1_out; end
      if (issue_valid_out === 1'b1 && issue_rob_id_out == 3'd1 && cyc_a < 0) begin
        cyc_a = c; a_o1 = issue_opr1_out; a_o2 = issue_opr2_out; end
      if (c == 0) begin cdb_valid_in = 2'b10; cdb_tag_in = {3'd4, 3'd0}; cdb_value_in = {32'h55, 32'h0}; end
      step(); cdb_valid_in = '0;
    end
    n_cmp++; if (cyc_b < 0 || cyc_a < 0 || cyc_a - cyc_b != exp_gap) begin
      n_bad++; $display("FAIL wake_order: got B@%0d A@%0d want A exactly %0d after B", cyc_b, cyc_a, exp_gap); end
    n_cmp++; if (a_o1 !== 32'h55 || a_o2 !== 32'd9) begin
      n_bad++; $display("FAIL wake_value: got o1=%0h o2=%0h want 55 9", a_o1, a_o2); end
    n_cmp++; if (b_o1 !== 32'h11) begin n_bad++; $display("FAIL wake_b_value: got %0h want 11", b_o1); end
  endtask

  task automatic test_forward();
    int lat;
    idle(); issue_ready_in = 1'b1; lat = 0;
    drive(4'd5, 1'b1, 3'd6, 32'hDEAD, 1'b0, 3'd0, 32'd3, 3'd3);
    cdb_valid_in = 2'b11; cdb_tag_in = {3'd6, 3'd6}; cdb_value_in = {32'hBB, 32'hAA};
    for (int c = 1; c <= 6; c++) begin
      step(); idle();
      if (issue_valid_out === 1'b1) begin lat = c; break; end
    end
    n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL fwd_latency: got %0d want %0d", lat, exp_lat); end
    n_cmp++; if (issue_opr1_out !== 32'hAA || issue_rob_id_out !== 3'd3) begin
      n_bad++; $display("FAIL fwd_value: got o1=%0h rob=%0d want AA 3", issue_opr1_out, issue_rob_id_out); end
    step();
  endtask

  task automatic test_dual_wake();
    bit seen;
    idle(); issue_ready_in = 1'b1; seen = 1'b0;
    drive(4'd7, 1'b1, 3'd1, 32'd0, 1'b1, 3'd2, 32'd0, 3'd5);
    step(); idle();
    cdb_valid_in = 2'b11; cdb_tag_in = {3'd1, 3'd2}; cdb_value_in = {32'h111, 32'h222};
    step(); cdb_valid_in = '0;
    for (int c = 0; c < 4 && !seen; c++) begin
      step();
      if (issue_valid_out === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (issue_opr1_out !== 32'h111 || issue_opr2_out !== 32'h222) begin
          n_bad++; $display("FAIL dual_wake: got o1=%0h o2=%0h want 111 222", issue_opr1_out, issue_opr2_out); end
      end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL dual_wake_timeout: got no issue want one"); end
    step();
  endtask

  task automatic test_full();
    int seen[$];
    idle(); issue_ready_in = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      drive(OP_W'(i), 1'b0, 3'd0, 32'(100 + i), 1'b0, 3'd0, 32'(i), ROB_W'(i));
      step();
      if (i == 7) begin n_cmp++; if (full_out !== 1'b0) begin n_bad++; $display("FAIL full_early: got %b want 0", full_out); end end
    end
    n_cmp++; if (full_out !== 1'b1) begin n_bad++; $display("FAIL full_set: got %b want 1", full_out); end
    drive(4'hF, 1'b0, 3'd0, 32'd200, 1'b0, 3'd0, 32'd200, 3'd7);
    step(); idle();
    n_cmp++; if ({full_out, issue_valid_out} !== 2'b11 || issue_opr1_out !== 32'd100 || issue_rob_id_out !== 3'd0) begin
      n_bad++; $display("FAIL full_hold: got full=%b v=%b o1=%0d rob=%0d want 1 1 100 0",
                        full_out, issue_valid_out, issue_opr1_out, issue_rob_id_out); end
    issue_ready_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (issue_valid_out === 1'b1) seen.push_back(int'(issue_opr1_out));
    end
    n_cmp++; if (seen.size() != 8) begin n_bad++; $display("FAIL full_drain_count: got %0d want 8", seen.size()); end
    for (int k = 0; k < seen.size() && k < 8; k++) begin
      n_cmp++; if (seen[k] != 101 + k) begin n_bad++; $display("FAIL full_order[%0d]: got %0d want %0d", k, seen[k], 101 + k); end
    end
  endtask

  task automatic test_flush();
    idle(); issue_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd1, 1'b0, 3'd0, 32'(300 + i), 1'b0, 3'd0, 32'd0, ROB_W'(i));
      step();
    end
    drive(4'd2, 1'b1, 3'd3, 32'd400, 1'b0, 3'd0, 32'd0, 3'd6);
    flush_in = 1'b1; cdb_valid_in = 2'b01; cdb_tag_in = {3'd0, 3'd3}; cdb_value_in = {32'd0, 32'd77};
    issue_ready_in = 1'b1;
    step(); idle();
    n_cmp++; if ({issue_valid_out, full_out} !== 2'b00) begin
      n_bad++; $display("FAIL flush_state: got valid=%b full=%b want 0 0", issue_valid_out, full_out); end
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++; if (issue_valid_out !== 1'b0) begin n_bad++; $display("FAIL flush_quiet[%0d]: got %b want 0", c, issue_valid_out); end
    end
  endtask

  task automatic test_async_reset();
    idle(); issue_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd9, 1'b0, 3'd0, 32'(500 + i), 1'b0, 3'd0, 32'd1, ROB_W'(i));
      step();
    end
    idle();
    n_cmp++; if (issue_valid_out !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got %b want 1", issue_valid_out); end
    #2 rst_n_in = 1'b0;
    #1;
    n_cmp++; if ({issue_valid_out, full_out} !== 2'b00 || issue_opr1_out !== 32'd0 || issue_rob_id_out !== 3'd0) begin
      n_bad++; $display("FAIL arst_now: got v=%b f=%b o1=%0d rob=%0d want 0 0 0 0",
                        issue_valid_out, full_out, issue_opr1_out, issue_rob_id_out); end
    #1 rst_n_in = 1'b1;
    model_reset();
    issue_ready_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (issue_valid_out !== 1'b0) begin n_bad++; $display("FAIL arst_empty[%0d]: got %b want 0", c, issue_valid_out); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      rdy_in         = ($urandom_range(0, 9) != 0);
      flush_in       = ($urandom_range(0, 149) == 0);
      issue_ready_in = ($urandom_range(0, 9) < 6);
      dec_valid_in   = ($urandom_range(0, 9) < 6);
      dec_op_in      = OP_W'($urandom);
      dec_wait1_in   = ($urandom_range(0, 9) < 4);
      dec_wait2_in   = ($urandom_range(0, 9) < 4);
      dec_tag1_in    = ROB_W'($urandom);
      dec_tag2_in    = ROB_W'($urandom);
      dec_val1_in    = $urandom;
      dec_val2_in    = $urandom;
      dec_rob_id_in  = ROB_W'($urandom);
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_valid_in[k] = ($urandom_range(0, 9) < 4);
        cdb_tag_in[k*ROB_W +: ROB_W] = ROB_W'($urandom);
        cdb_value_in[k*32 +: 32] = $urandom;
      end
      step();
      n_cmp++; if (issue_valid_out !== m_valid || full_out !== m_full) begin
        n_bad++; $display("FAIL rand_ctrl@%0d: got v=%b f=%b want v=%b f=%b", c, issue_valid_out, full_out, m_valid, m_full); end
      if (m_valid) begin
        n_cmp++;
        if ({issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out} !== {m_out.op, m_out.v1, m_out.v2, m_out.rob}) begin
          n_bad++; $display("FAIL rand_data@%0d: got op=%0h o1=%0h o2=%0h rob=%0h want op=%0h o1=%0h o2=%0h rob=%0h", c,
                            issue_op_out, issue_opr1_out, issue_opr2_out, issue_rob_id_out,
                            m_out.op, m_out.v1, m_out.v2, m_out.rob); end
      end
    end
    idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_lat = BYP ? 1 : 2;
    model_reset();
    test_reset();
    test_basic();
    test_wakeup_order();
    test_forward();
    test_dual_wake();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
